alu_share_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters: requester 0 is the main datapath and requester 1 is the address/branch helper.
- Arbitration is round-robin.
- Operands are captured into registers, the ALU is evaluated for one cycle, and the result and zero flag are returned on a per-requester valid/ready response channel.
- Sits between the decode/control logic and the ALU in the multi-cycle CPU.

---
 rtl/alu_share_arbiter_pkg.sv | 11 +
 rtl/alu_share_arbiter_if.sv | 32 +++
 rtl/alu_share_arbiter_alu.sv | 24 ++
 rtl/alu_share_arbiter.sv | 75 +++++++
 tb/tb_alu_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: ALU codes, requester IDs and FSM encoding for the shared-ALU arbiter
package alu_share_arbiter_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: two request channels and two response channels sharing one ALU
interface alu_share_arbiter_if #(parameter int DATA_W = 32, parameter int CTRL_W = 4);
  logic              req0_valid_i, req0_ready_o;
  logic [DATA_W-1:0] req0_src1_i, req0_src2_i;
  logic [CTRL_W-1:0] req0_ctrl_i;
  logic              req1_valid_i, req1_ready_o;
  logic [DATA_W-1:0] req1_src1_i, req1_src2_i;
  logic [CTRL_W-1:0] req1_ctrl_i;
  logic              rsp0_valid_o, rsp0_ready_i, rsp0_zero_o;
  logic [DATA_W-1:0] rsp0_result_o;
  logic              rsp1_valid_o, rsp1_ready_i, rsp1_zero_o;
  logic [DATA_W-1:0] rsp1_result_o;
  logic              busy_o;
  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
    output rsp1_valid_o, rsp1_result_o, rsp1_zero_o,
    input  rsp0_ready_i, rsp1_ready_i,
    output busy_o
  );
  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
    input  rsp1_valid_o, rsp1_result_o, rsp1_zero_o,
    output rsp0_ready_i, rsp1_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// alu_share_arbiter_alu: combinational ALU; unknown control codes yield zero
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);
  logic [DATA_W-1:0] slt;
  assign slt = {{(DATA_W-1){1'b0}}, src1_i < src2_i};
  always_comb begin
    result_o = ctrl_i == CTRL_W'(ALU_AND) ? src1_i & src2_i :
               ctrl_i == CTRL_W'(ALU_OR)  ? src1_i | src2_i :
               ctrl_i == CTRL_W'(ALU_ADD) ? src1_i + src2_i :
               ctrl_i == CTRL_W'(ALU_SUB) ? src1_i - src2_i :
               ctrl_i == CTRL_W'(ALU_SLT) ? slt : '0;
  end
  assign zero_o = result_o == '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters, capture/execute/respond
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  alu_share_arbiter_if.slave bus
);
  state_t            state;
  logic              last_grant, owner, grant, any_valid, accept, alu_zero;
  logic [DATA_W-1:0] src1_q, src2_q, alu_result;
  logic [CTRL_W-1:0] ctrl_q;
  assign any_valid = bus.req0_valid_i | bus.req1_valid_i;
  assign grant = (bus.req0_valid_i & bus.req1_valid_i) ? ~last_grant : bus.req1_valid_i;
  // ready is gated by reset so nothing looks accepted while the block is held in reset
  assign accept = rst_i && state == IDLE && any_valid;
  assign bus.req0_ready_o = accept && grant == REQ0;
  assign bus.req1_ready_o = accept && grant == REQ1;
  assign bus.busy_o = state != IDLE;
  alu_share_arbiter_alu #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_alu (
    .src1_i(src1_q),
    .src2_i(src2_q),
    .ctrl_i(ctrl_q),
    .result_o(alu_result),
    .zero_o(alu_zero)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      last_grant <= REQ1;
      owner <= REQ0;
      src1_q <= '0;
      src2_q <= '0;
      ctrl_q <= '0;
      bus.rsp0_valid_o <= 1'b0;
      bus.rsp1_valid_o <= 1'b0;
      bus.rsp0_result_o <= '0;
      bus.rsp1_result_o <= '0;
      bus.rsp0_zero_o <= 1'b0;
      bus.rsp1_zero_o <= 1'b0;
    end else
      case (state)
        IDLE:
          if (any_valid) begin
            src1_q <= grant ? bus.req1_src1_i : bus.req0_src1_i;
            src2_q <= grant ? bus.req1_src2_i : bus.req0_src2_i;
            ctrl_q <= grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;
            owner <= grant;
            last_grant <= grant;
            state <= EXEC;
          end
        EXEC: begin
          if (owner == REQ1) begin
            bus.rsp1_result_o <= alu_result;
            bus.rsp1_zero_o <= alu_zero;
            bus.rsp1_valid_o <= 1'b1;
          end else begin
            bus.rsp0_result_o <= alu_result;
            bus.rsp0_zero_o <= alu_zero;
            bus.rsp0_valid_o <= 1'b1;
          end
          state <= RESP;
        end
        RESP:
          if (owner == REQ1 ? bus.rsp1_ready_i : bus.rsp0_ready_i) begin
            bus.rsp0_valid_o <= 1'b0;
            bus.rsp1_valid_o <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed plan plus random traffic against a transaction-level model
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(4)) bus ();
  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  bit m_busy = 1'b0;
  bit m_owner = 1'b0;
  bit m_last = 1'b1;
  int m_age = 0;
  logic [31:0] m_res = '0;
  bit acc[2];
  int grants[$];
  int own_q[$];
  logic [31:0] res_q[$];
  logic [31:0] zero_q[$];
  logic s_rdy[2], s_rv[2], s_busy;
  logic [31:0] s_res[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] rnd_val();
    case ($urandom_range(3))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [3:0] rnd_ctrl();
    case ($urandom_range(5))
      0: return ALU_AND;
      1: return ALU_OR;
      2: return ALU_ADD;
      3: return ALU_SUB;
      4: return ALU_SLT;
      default: return 4'($urandom);
    endcase
  endfunction
  task automatic set_req(input int n, input bit val, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid_i = val; bus.req0_ctrl_i = c; bus.req0_src1_i = a; bus.req0_src2_i = b;
    end else begin
      bus.req1_valid_i = val; bus.req1_ctrl_i = c; bus.req1_src1_i = a; bus.req1_src2_i = b;
    end
  endtask
  // one clock: compare at the falling edge, advance the model at the rising edge
  task automatic cycle();
    bit v[2], rr[2], er[2], ev[2];
    bit g;
    logic [31:0] s1[2], s2[2];
    logic [3:0] c[2];
    @(negedge clk);
    acc[0] = 1'b0; acc[1] = 1'b0;
    v[0] = bus.req0_valid_i; v[1] = bus.req1_valid_i;
    rr[0] = bus.rsp0_ready_i; rr[1] = bus.rsp1_ready_i;
    s1[0] = bus.req0_src1_i; s1[1] = bus.req1_src1_i;
    s2[0] = bus.req0_src2_i; s2[1] = bus.req1_src2_i;
    c[0] = bus.req0_ctrl_i; c[1] = bus.req1_ctrl_i;
    s_rdy[0] = bus.req0_ready_o; s_rdy[1] = bus.req1_ready_o;
    s_rv[0] = bus.rsp0_valid_o; s_rv[1] = bus.rsp1_valid_o;
    s_res[0] = bus.rsp0_result_o; s_res[1] = bus.rsp1_result_o;
    s_busy = bus.busy_o;
    if (!rst_n) begin
      m_busy = 1'b0; m_last = 1'b1;
      check("rst_ready0", s_rdy[0], 0);
      check("rst_ready1", s_rdy[1], 0);
      check("rst_rsp0_valid", s_rv[0], 0);
      check("rst_rsp1_valid", s_rv[1], 0);
      check("rst_busy", s_busy, 0);
      check("rst_result0", s_res[0], 0);
      check("rst_result1", s_res[1], 0);
      check("rst_zero0", bus.rsp0_zero_o, 0);
      check("rst_zero1", bus.rsp1_zero_o, 0);
    end else begin
      g = (v[0] && v[1]) ? !m_last : v[1];
      for (int n = 0; n < 2; n++) begin
        er[n] = !m_busy && v[n] && g == n;
        ev[n] = m_busy && m_age >= 1 && m_owner == n;
      end
      check("ready0", s_rdy[0], er[0]);
      check("ready1", s_rdy[1], er[1]);
      check("rsp0_valid", s_rv[0], ev[0]);
      check("rsp1_valid", s_rv[1], ev[1]);
      check("busy", s_busy, m_busy);
      if (ev[0]) begin
        check("rsp0_result", s_res[0], m_res);
        check("rsp0_zero", bus.rsp0_zero_o, m_res == 0);
      end
      if (ev[1]) begin
        check("rsp1_result", s_res[1], m_res);
        check("rsp1_zero", bus.rsp1_zero_o, m_res == 0);
      end
      if (s_rdy[0]) grants.push_back(0);
      if (s_rdy[1]) grants.push_back(1);
      if (s_rv[0] && rr[0]) begin own_q.push_back(0); res_q.push_back(s_res[0]); zero_q.push_back(32'(bus.rsp0_zero_o)); end
      if (s_rv[1] && rr[1]) begin own_q.push_back(1); res_q.push_back(s_res[1]); zero_q.push_back(32'(bus.rsp1_zero_o)); end
    end
    @(posedge clk);
    if (rst_n) begin
      if (!m_busy) begin
        if (v[0] || v[1]) begin
          m_busy = 1'b1; m_owner = g; m_last = g; m_age = 0;
          m_res = ref_alu(c[g], s1[g], s2[g]);
          acc[g] = 1'b1;
        end
      end else if (m_age >= 1 && rr[m_owner]) m_busy = 1'b0;
      else m_age++;
    end
    #1;
  endtask
  task automatic clear_logs();
    grants.delete(); own_q.delete(); res_q.delete(); zero_q.delete();
  endtask
  task automatic run_until_done(input int k);
    int t = 0;
    while (res_q.size() < k && t < 60) begin
      cycle();
      if (acc[0]) bus.req0_valid_i = 1'b0;
      if (acc[1]) bus.req1_valid_i = 1'b0;
      t++;
    end
    check("done_count", res_q.size(), k);
  endtask
  initial begin
    int t;
    set_req(0, 1, ALU_ADD, 5, 7);
    set_req(1, 1, ALU_OR, 0, 0);
    bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) cycle();
    bus.req1_valid_i = 1'b0;
    rst_n = 1'b1;
    // single request
    clear_logs();
    cycle();
    check("single_accept", acc[0], 1);
    bus.req0_valid_i = 1'b0;
    repeat (3) cycle();
    check("single_count", res_q.size(), 1);
    if (res_q.size() >= 1) begin
      check("single_owner", own_q[0], 0);
      check("single_result", res_q[0], 12);
      check("single_zero", zero_q[0], 0);
    end
    // tie right after reset goes to requester 0
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    clear_logs();
    set_req(0, 1, ALU_SUB, 9, 9);
    set_req(1, 1, ALU_OR, 32'hF0, 32'h0F);
    run_until_done(2);
    if (res_q.size() >= 2) begin
      check("tie_owner0", own_q[0], 0);
      check("tie_result0", res_q[0], 0);
      check("tie_zero0", zero_q[0], 1);
      check("tie_owner1", own_q[1], 1);
      check("tie_result1", res_q[1], 32'hFF);
      check("tie_zero1", zero_q[1], 0);
    end
    // fairness under continuous contention
    clear_logs();
    set_req(0, 1, rnd_ctrl(), rnd_val(), rnd_val());
    set_req(1, 1, rnd_ctrl(), rnd_val(), rnd_val());
    t = 0;
    while (grants.size() < 6 && t < 60) begin
      cycle();
      if (acc[0]) set_req(0, 1, rnd_ctrl(), rnd_val(), rnd_val());
      if (acc[1]) set_req(1, 1, rnd_ctrl(), rnd_val(), rnd_val());
      t++;
    end
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    check("rr_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) check($sformatf("rr_grant%0d", i), grants[i], i % 2);
    run_until_done(6);
    // backpressure on requester 1
    clear_logs();
    bus.rsp1_ready_i = 1'b0;
    set_req(1, 1, ALU_SLT, 3, 32'hFFFF_FFFF);
    t = 0;
    while (!acc[1] && t < 10) begin cycle(); t++; end
    check("bp_accept", acc[1], 1);
    bus.req1_valid_i = 1'b0;
    set_req(0, 1, ALU_AND, 32'hF0F0, 32'hFF00);
    cycle();
    repeat (5) begin
      cycle();
      check("bp_valid", s_rv[1], 1);
      check("bp_result", s_res[1], 1);
      check("bp_ready0", s_rdy[0], 0);
      check("bp_ready1", s_rdy[1], 0);
    end
    bus.rsp1_ready_i = 1'b1;
    cycle();
    cycle();
    check("bp_idle_busy", s_busy, 0);
    check("bp_idle_ready0", s_rdy[0], 1);
    if (acc[0]) bus.req0_valid_i = 1'b0;
    run_until_done(2);
    if (res_q.size() >= 2) begin
      check("bp_owner", own_q[0], 1);
      check("bp_final", res_q[0], 1);
      check("and_result", res_q[1], 32'hF000);
    end
    // invalid code, then additive wrap
    clear_logs();
    set_req(0, 1, 4'b1111, $urandom | 32'h1, 32'hFFFF_FFFF);
    run_until_done(1);
    set_req(0, 1, ALU_ADD, 32'hFFFF_FFFF, 1);
    run_until_done(2);
    if (res_q.size() >= 2) begin
      check("bad_result", res_q[0], 0);
      check("bad_zero", zero_q[0], 1);
      check("wrap_result", res_q[1], 0);
      check("wrap_zero", zero_q[1], 1);
    end
    // reset while executing
    clear_logs();
    set_req(0, 1, ALU_ADD, 1, 2);
    cycle();
    check("mid_accept", acc[0], 1);
    bus.req0_valid_i = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    check("mid_no_rsp", res_q.size(), 0);
    set_req(0, 1, ALU_OR, 1, 2);
    set_req(1, 1, ALU_OR, 4, 8);
    cycle();
    check("mid_tie_ready0", s_rdy[0], 1);
    check("mid_tie_ready1", s_rdy[1], 0);
    run_until_done(2);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid_i || acc[0]) set_req(0, $urandom_range(9) < 6, rnd_ctrl(), rnd_val(), rnd_val());
      if (!bus.req1_valid_i || acc[1]) set_req(1, $urandom_range(9) < 6, rnd_ctrl(), rnd_val(), rnd_val());
      bus.rsp0_ready_i = $urandom_range(9) < 7;
      bus.rsp1_ready_i = $urandom_range(9) < 7;
      cycle();
    end
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
    repeat (4) cycle();
    check("drain_busy", s_busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
